// File: rtl/cfg_regfile_wb_pkg.sv
// rtl/cfg_regfile_wb_pkg.sv - shared constants, Wishbone FSM states and host address fields
package cfg_regfile_wb_pkg;

  localparam logic [15:0] DONE_ADR_DEF  = 16'h0100;
  localparam logic [15:0] READY_ADR_DEF = 16'h0104;

  typedef enum logic [1:0] {
    WB_IDLE  = 2'd0,
    WB_FETCH = 2'd1,
    WB_ACK   = 2'd2
  } wb_state_t;

  // Host address layout: {status select, side, channel[a-1:0]}
  function automatic int host_side_pos(input int a);
    return a;
  endfunction

  function automatic int host_stat_pos(input int a);
    return a + 1;
  endfunction

endpackage

// File: rtl/cfg_regfile_wb_slave.sv
// rtl/cfg_regfile_wb_slave.sv - per-side Wishbone slave FSM with sticky core-ready flag
module cfg_regfile_wb_slave
  import cfg_regfile_wb_pkg::*;
#(
  parameter int          N_CH      = 32,
  parameter int          CFG_W     = 3,
  parameter logic [15:0] DONE_ADR  = DONE_ADR_DEF,
  parameter logic [15:0] READY_ADR = READY_ADR_DEF
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CH-1:0][CFG_W-1:0]  i_words,
  input  logic                        i_cfg_done,
  input  logic [31:0]                 i_wb_adr,
  input  logic [31:0]                 i_wb_dat,
  input  logic [3:0]                  i_wb_sel,
  input  logic                        i_wb_we,
  input  logic                        i_wb_cyc,
  input  logic                        i_wb_stb,
  output logic [31:0]                 o_wb_dat,
  output logic                        o_wb_ack,
  output logic                        o_wb_err,
  output logic                        o_core_ready
);

  localparam int A = $clog2(N_CH);

  wb_state_t   r_state;
  logic [31:0] r_dat;
  logic        r_ack;
  logic        r_ready;
  logic        w_req;
  logic [A-1:0] w_ch;
  logic [31:0] w_rd_val;
  logic        w_unused;

  assign w_req    = i_wb_stb & i_wb_cyc;
  assign w_ch     = i_wb_adr[A+1:2];
  assign w_unused = ^{i_wb_dat, i_wb_sel, i_wb_adr};

  always_comb begin
    w_rd_val = 32'(i_words[w_ch]);
    if (i_wb_adr[15:0] == DONE_ADR)
      w_rd_val = {31'b0, i_cfg_done};
    else if (i_wb_adr[15:0] == READY_ADR)
      w_rd_val = {31'b0, r_ready};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= WB_IDLE;
      r_dat   <= 32'b0;
      r_ack   <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      case (r_state)
        WB_IDLE: begin
          r_ack <= 1'b0;
          if (w_req && i_wb_we) begin
            r_state <= WB_ACK;
            r_ack   <= 1'b1;
            if (i_wb_adr[15:0] == READY_ADR)
              r_ready <= 1'b1;
          end else if (w_req) begin
            r_state <= WB_FETCH;
          end
        end
        WB_FETCH: begin
          // A master that gives up mid-read gets no ack.
          if (w_req) begin
            r_dat   <= w_rd_val;
            r_ack   <= 1'b1;
            r_state <= WB_ACK;
          end else begin
            r_state <= WB_IDLE;
          end
        end
        WB_ACK: begin
          r_ack   <= 1'b0;
          r_state <= WB_IDLE;
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= WB_IDLE;
        end
      endcase
    end
  end

  assign o_wb_dat     = r_dat;
  assign o_wb_ack     = r_ack;
  assign o_wb_err     = 1'b0;
  assign o_core_ready = r_ready;

endmodule

// File: rtl/cfg_regfile_wb.sv
// rtl/cfg_regfile_wb.sv - channel config register file, host port plus two Wishbone slaves; optional CFG_INT_LOCK_EN
module cfg_regfile_wb
  import cfg_regfile_wb_pkg::*;
#(
  parameter int          N_CH      = 32,
  parameter int          CFG_W     = 3,
  parameter logic [15:0] DONE_ADR  = DONE_ADR_DEF,
  parameter logic [15:0] READY_ADR = READY_ADR_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cs,
  input  logic                      rs,
  input  logic                      ws,
  input  logic [$clog2(N_CH)+1:0]   addrs,
  input  logic [7:0]                w_data,
  output logic [7:0]                r_data,
  input  logic [31:0]               i_wb_adr_e,
  input  logic [31:0]               i_wb_dat_e,
  input  logic [3:0]                i_wb_sel_e,
  input  logic                      i_wb_we_e,
  input  logic                      i_wb_cyc_e,
  input  logic                      i_wb_stb_e,
  output logic [31:0]               o_wb_dat_e,
  output logic                      o_wb_ack_e,
  output logic                      o_wb_err_e,
  input  logic [31:0]               i_wb_adr_d,
  input  logic [31:0]               i_wb_dat_d,
  input  logic [3:0]                i_wb_sel_d,
  input  logic                      i_wb_we_d,
  input  logic                      i_wb_cyc_d,
  input  logic                      i_wb_stb_d,
  output logic [31:0]               o_wb_dat_d,
  output logic                      o_wb_ack_d,
  output logic                      o_wb_err_d,
  output logic                      cfg_done_e,
  output logic                      cfg_done_d,
  output logic                      core_ready_e,
  output logic                      core_ready_d
);

  localparam int A    = $clog2(N_CH);
  localparam int SIDE = host_side_pos(A);
  localparam int STAT = host_stat_pos(A);

  logic [N_CH-1:0][CFG_W-1:0] r_word_e, r_word_d;
  logic [N_CH-1:0]            r_cfg_e, r_cfg_d;
  logic                       r_done_e, r_done_d;
  logic                       r_rd_d, r_wr_d, r_rd_pend;
  logic [A+1:0]               r_rd_addr;
  logic                       w_rd, w_wr, w_commit, w_lock_drop;
  logic [A-1:0]               w_ch, w_rch;
  logic [7:0]                 w_rd_val;
  logic                       w_unused;

`ifdef CFG_INT_LOCK_EN
  logic r_lock_e, r_lock_d;
  assign w_lock_drop = addrs[SIDE] ? core_ready_e : core_ready_d;
`else
  assign w_lock_drop = 1'b0;
`endif

  assign w_rd     = cs & rs;
  assign w_wr     = cs & ws;
  assign w_commit = r_wr_d & ~w_wr;
  assign w_ch     = addrs[A-1:0];
  assign w_rch    = r_rd_addr[A-1:0];
  assign w_unused = ^w_data;

  always_comb begin
    w_rd_val = 8'(r_rd_addr[SIDE] ? r_word_e[w_rch] : r_word_d[w_rch]);
    if (r_rd_addr[STAT]) begin
      w_rd_val = {7'b0, r_rd_addr[SIDE] ? core_ready_e : core_ready_d};
`ifdef CFG_INT_LOCK_EN
      w_rd_val[1] = r_rd_addr[SIDE] ? r_lock_e : r_lock_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_word_e  <= '0;
      r_word_d  <= '0;
      r_cfg_e   <= '0;
      r_cfg_d   <= '0;
      r_done_e  <= 1'b0;
      r_done_d  <= 1'b0;
      r_rd_d    <= 1'b0;
      r_wr_d    <= 1'b0;
      r_rd_pend <= 1'b0;
      r_rd_addr <= '0;
      r_data    <= 8'b0;
`ifdef CFG_INT_LOCK_EN
      r_lock_e  <= 1'b0;
      r_lock_d  <= 1'b0;
`endif
    end else begin
      r_rd_d    <= w_rd;
      r_wr_d    <= w_wr;
      // Read edge is captured with its address and served one clock later.
      r_rd_pend <= w_rd & ~r_rd_d;
      if (w_rd & ~r_rd_d)
        r_rd_addr <= addrs;
      if (r_rd_pend)
        r_data <= w_rd_val;
      if (w_commit && !addrs[STAT]) begin
        if (w_lock_drop) begin
`ifdef CFG_INT_LOCK_EN
          if (addrs[SIDE]) r_lock_e <= 1'b1;
          else             r_lock_d <= 1'b1;
`endif
        end else if (addrs[SIDE]) begin
          r_word_e[w_ch] <= w_data[CFG_W-1:0];
          r_cfg_e[w_ch]  <= 1'b1;
        end else begin
          r_word_d[w_ch] <= w_data[CFG_W-1:0];
          r_cfg_d[w_ch]  <= 1'b1;
        end
      end
      r_done_e <= &r_cfg_e;
      r_done_d <= &r_cfg_d;
    end
  end

  assign cfg_done_e = r_done_e;
  assign cfg_done_d = r_done_d;

  cfg_regfile_wb_slave #(
    .N_CH(N_CH), .CFG_W(CFG_W), .DONE_ADR(DONE_ADR), .READY_ADR(READY_ADR)
  ) u_slave_e (
    .clk(clk), .reset(reset), .i_words(r_word_e), .i_cfg_done(r_done_e),
    .i_wb_adr(i_wb_adr_e), .i_wb_dat(i_wb_dat_e), .i_wb_sel(i_wb_sel_e),
    .i_wb_we(i_wb_we_e), .i_wb_cyc(i_wb_cyc_e), .i_wb_stb(i_wb_stb_e),
    .o_wb_dat(o_wb_dat_e), .o_wb_ack(o_wb_ack_e), .o_wb_err(o_wb_err_e),
    .o_core_ready(core_ready_e)
  );

  cfg_regfile_wb_slave #(
    .N_CH(N_CH), .CFG_W(CFG_W), .DONE_ADR(DONE_ADR), .READY_ADR(READY_ADR)
  ) u_slave_d (
    .clk(clk), .reset(reset), .i_words(r_word_d), .i_cfg_done(r_done_d),
    .i_wb_adr(i_wb_adr_d), .i_wb_dat(i_wb_dat_d), .i_wb_sel(i_wb_sel_d),
    .i_wb_we(i_wb_we_d), .i_wb_cyc(i_wb_cyc_d), .i_wb_stb(i_wb_stb_d),
    .o_wb_dat(o_wb_dat_d), .o_wb_ack(o_wb_ack_d), .o_wb_err(o_wb_err_d),
    .o_core_ready(core_ready_d)
  );

endmodule

// File: tb/tb_cfg_regfile_wb.sv
// tb/tb_cfg_regfile_wb.sv - randomized directed bench for cfg_regfile_wb against a behavioural model
module tb_cfg_regfile_wb;

`ifdef CFG_INT_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cs = 1'b0, rs = 1'b0, ws = 1'b0;
  logic [6:0]  addrs = '0;
  logic [7:0]  w_data = '0;
  logic [7:0]  r_data;
  logic [31:0] adr_e = '0, dat_e = '0, adr_d = '0, dat_d = '0;
  logic [3:0]  sel_e = '0, sel_d = '0;
  logic        we_e = 0, cyc_e = 0, stb_e = 0, we_d = 0, cyc_d = 0, stb_d = 0;
  logic [31:0] o_dat_e, o_dat_d;
  logic        ack_e, ack_d, err_e, err_d;
  logic        done_e, done_d, ready_e, ready_d;

  int checks = 0;
  int errors = 0;

  logic [2:0] m_word [2][32];
  bit         m_cfg  [2][32];
  bit         m_ready[2];
  bit         m_lock [2];

  cfg_regfile_wb dut (
    .clk(clk), .reset(reset), .cs(cs), .rs(rs), .ws(ws), .addrs(addrs),
    .w_data(w_data), .r_data(r_data),
    .i_wb_adr_e(adr_e), .i_wb_dat_e(dat_e), .i_wb_sel_e(sel_e), .i_wb_we_e(we_e),
    .i_wb_cyc_e(cyc_e), .i_wb_stb_e(stb_e), .o_wb_dat_e(o_dat_e), .o_wb_ack_e(ack_e),
    .o_wb_err_e(err_e),
    .i_wb_adr_d(adr_d), .i_wb_dat_d(dat_d), .i_wb_sel_d(sel_d), .i_wb_we_d(we_d),
    .i_wb_cyc_d(cyc_d), .i_wb_stb_d(stb_d), .o_wb_dat_d(o_dat_d), .o_wb_ack_d(ack_d),
    .o_wb_err_d(err_d),
    .cfg_done_e(done_e), .cfg_done_d(done_d), .core_ready_e(ready_e), .core_ready_d(ready_d)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      m_ready[s] = 0;
      m_lock[s]  = 0;
      for (int c = 0; c < 32; c++) begin
        m_word[s][c] = '0;
        m_cfg[s][c]  = 0;
      end
    end
  endtask

  function automatic bit m_done(input int s);
    int n = 0;
    for (int c = 0; c < 32; c++) n += int'(m_cfg[s][c]);
    return n == 32;
  endfunction

  function automatic logic [31:0] m_wb_read(input int s, input logic [31:0] adr);
    if (adr[15:0] == 16'h0100) return {31'b0, m_done(s)};
    if (adr[15:0] == 16'h0104) return {31'b0, m_ready[s]};
    return 32'(m_word[s][(adr[15:0] / 4) % 32]);
  endfunction

  function automatic logic [7:0] m_host_read(input int s, input bit stat, input int ch);
    if (stat) return {6'b0, LOCK & m_lock[s], m_ready[s]};
    return 8'(m_word[s][ch]);
  endfunction

  task automatic set_wb(input int s, input logic [31:0] adr, input logic [31:0] dat,
                        input logic we, input logic req);
    if (s == 1) begin
      adr_e = adr; dat_e = dat; we_e = we; cyc_e = req; stb_e = req; sel_e = 4'hF;
    end else begin
      adr_d = adr; dat_d = dat; we_d = we; cyc_d = req; stb_d = req; sel_d = 4'hF;
    end
  endtask

  task automatic wb_xfer(input int s, input logic [31:0] adr, input logic [31:0] dat,
                         input logic we, output logic [31:0] rd, output int lat);
    bit got = 0;
    rd = 'x;
    lat = 0;
    @(posedge clk); #1;
    set_wb(s, adr, dat, we, 1'b1);
    repeat (8) begin
      if (!got) begin
        @(posedge clk); #1;
        lat++;
        if ((s == 1) ? ack_e : ack_d) begin
          got = 1;
          rd = (s == 1) ? o_dat_e : o_dat_d;
        end
      end
    end
    if (!got) lat = 99;
    set_wb(s, 32'h0, 32'h0, 1'b0, 1'b0);
    if (we && adr[15:0] == 16'h0104) m_ready[s] = 1;
    @(posedge clk); #1;
  endtask

  task automatic host_write(input int s, input bit stat, input int ch, input logic [7:0] d);
    @(posedge clk); #1;
    addrs = {stat, s[0], ch[4:0]};
    w_data = d;
    cs = 1; ws = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    cs = 0; ws = 0;
    @(posedge clk); #1;
    if (!stat) begin
      if (LOCK && m_ready[s]) m_lock[s] = 1;
      else begin
        m_word[s][ch] = d[2:0];
        m_cfg[s][ch]  = 1;
      end
    end
  endtask

  task automatic host_read(input int s, input bit stat, input int ch, output logic [7:0] d);
    @(posedge clk); #1;
    addrs = {stat, s[0], ch[4:0]};
    cs = 1; rs = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    d = r_data;
    cs = 0; rs = 0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, r32, adr;
    logic [7:0]  hd;
    logic [2:0]  oldw, neww;
    int lat, s, ch;

    model_reset();
    repeat (3) @(posedge clk);
    #1 reset = 0;
    check("rst_rdata", 32'(r_data), 32'h0);
    check("rst_ack", {ack_e, ack_d, err_e, err_d}, 32'h0);
    check("rst_flags", {done_e, done_d, ready_e, ready_d}, 32'h0);
    check("rst_wbdat", o_dat_e | o_dat_d, 32'h0);
    host_read(1, 0, 5, hd);
    check("rst_host_rd_enc5", 32'(hd), 32'h0);

    host_write(0, 0, 3, 8'hFE);
    wb_xfer(0, 32'h0C, 32'h0, 1'b0, rd, lat);
    check("dec3_lat", lat, 2);
    check("dec3_data", rd, 32'h6);

    for (int c = 0; c < 32; c++) begin
      host_write(1, 0, c, 8'($urandom));
      if (c == 30) check("done_early", 32'(done_e), 32'h0);
    end
    check("done_lag", 32'(done_e), 32'h0);
    @(posedge clk); #1;
    check("done_set", 32'(done_e), 32'h1);
    wb_xfer(1, 32'h100, 32'h0, 1'b0, rd, lat);
    check("done_wb_enc", rd, m_wb_read(1, 32'h100));
    wb_xfer(0, 32'h100, 32'h0, 1'b0, rd, lat);
    check("done_wb_dec", rd, 32'h0);

    host_write(1, 1, 2, 8'h07);
    wb_xfer(1, 32'h08, 32'h0, 1'b0, rd, lat);
    check("stat_write_ignored", rd, m_wb_read(1, 32'h08));

    for (int i = 0; i < 60; i++) begin
      s  = int'($urandom_range(0, 1));
      ch = int'($urandom_range(0, 31));
      case ($urandom_range(0, 2))
        0: host_write(s, 0, ch, 8'($urandom));
        1: begin
          r32 = $urandom;
          adr = {r32[31:16], r32[15:9], r32[8], 1'b1, ch[4:0], r32[1:0]};
          if (r32[3]) adr = 32'(ch * 4);
          wb_xfer(s, adr, 32'h0, 1'b0, rd, lat);
          check("rand_wb_rd", rd, m_wb_read(s, adr));
        end
        default: begin
          host_read(s, 0, ch, hd);
          check("rand_host_rd", 32'(hd), 32'(m_host_read(s, 0, ch)));
        end
      endcase
    end

    wb_xfer(1, 32'h104, 32'h1, 1'b1, rd, lat);
    check("ready_wr_lat", lat, 1);
    check("ready_flags", {ready_e, ready_d}, 32'h2);
    host_read(1, 1, 0, hd);
    check("ready_host_stat", 32'(hd), 32'(m_host_read(1, 1, 0)));
    check("ready_host_stat_val", 32'(hd), 32'h01);
    wb_xfer(1, 32'h104, 32'h0, 1'b0, rd, lat);
    check("ready_wb_enc", rd, 32'h1);
    wb_xfer(0, 32'h104, 32'h0, 1'b0, rd, lat);
    check("ready_wb_dec", rd, 32'h0);
    wb_xfer(0, 32'h20, 32'hFFFF_FFFF, 1'b1, rd, lat);
    check("other_wr_lat", lat, 1);
    check("other_wr_noready", 32'(ready_d), 32'h0);
    wb_xfer(0, 32'h20, 32'h0, 1'b0, rd, lat);
    check("other_wr_discard", rd, m_wb_read(0, 32'h20));

    host_write(1, 0, 0, 8'h05);
    wb_xfer(1, 32'h0, 32'h0, 1'b0, rd, lat);
    check("lock_word", rd, m_wb_read(1, 32'h0));
    host_read(1, 1, 0, hd);
    check("lock_stat", 32'(hd), 32'(m_host_read(1, 1, 0)));

    @(posedge clk); #1;
    set_wb(1, 32'h14, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    set_wb(1, 32'h0, 32'h0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("abort_noack", 32'(ack_e), 32'h0);
    end
    wb_xfer(1, 32'h14, 32'h0, 1'b0, rd, lat);
    check("abort_next_lat", lat, 2);
    check("abort_next_data", rd, m_wb_read(1, 32'h14));

    @(posedge clk); #1;
    set_wb(1, 32'h18, 32'h0, 1'b0, 1'b1);
    set_wb(0, 32'h0C, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check("dual_early", {ack_e, ack_d}, 32'h0);
    @(posedge clk); #1;
    check("dual_ack", {ack_e, ack_d}, 32'h3);
    check("dual_dat_e", o_dat_e, m_wb_read(1, 32'h18));
    check("dual_dat_d", o_dat_d, m_wb_read(0, 32'h0C));
    set_wb(1, 32'h0, 32'h0, 1'b0, 1'b0);
    set_wb(0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;

    oldw = m_word[0][9];
    neww = oldw ^ 3'b101;
    @(posedge clk); #1;
    addrs = {1'b0, 1'b0, 5'd9};
    w_data = {5'b10101, neww};
    cs = 1; ws = 1;
    @(posedge clk); #1;
    set_wb(0, 32'h24, 32'h0, 1'b0, 1'b1);
    @(posedge clk); #1;
    cs = 0; ws = 0;
    @(posedge clk); #1;
    check("collide_ack", 32'(ack_d), 32'h1);
    check("collide_old", o_dat_d, 32'(oldw));
    set_wb(0, 32'h0, 32'h0, 1'b0, 1'b0);
    m_word[0][9] = neww;
    m_cfg[0][9]  = 1;
    @(posedge clk); #1;
    wb_xfer(0, 32'h24, 32'h0, 1'b0, rd, lat);
    check("collide_new", rd, 32'(neww));

    @(posedge clk); #1;
    set_wb(1, 32'h1C, 32'h0, 1'b0, 1'b1);
    addrs = {1'b1, 1'b1, 5'd0};
    cs = 1; rs = 1;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    cs = 0; rs = 0;
    set_wb(1, 32'h0, 32'h0, 1'b0, 1'b0);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("midrst_noack", 32'(ack_e), 32'h0);
      check("midrst_rdata", 32'(r_data), 32'h0);
    end
    check("midrst_flags", {done_e, done_d, ready_e, ready_d}, 32'h0);
    wb_xfer(1, 32'h1C, 32'h0, 1'b0, rd, lat);
    check("midrst_word", rd, m_wb_read(1, 32'h1C));
    host_read(0, 0, 3, hd);
    check("midrst_host", 32'(hd), 32'(m_host_read(0, 0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cfg_regfile_wb.md
Name: cfg_regfile_wb

Overview:
Parametrised channel-configuration register file.
- Host parallel port (cs/rs/ws) writes and reads per-channel mode words for N_CH encoder and N_CH decoder channels.
- Two independent Wishbone slave ports (encoder side, decoder side) let the cores read their channel words, poll config-done and signal core-ready.
- The whole block is synchronous to one clock. Host strobes are sampled and edge-detected rather than used as clocks.

Parameters:
N_CH, 32, channels per side; power of two, 2..256; A = $clog2(N_CH)
CFG_W, 3, bits per channel configuration word, 1..8
DONE_ADR, 16'h0100, Wishbone sub-address of the config-done status register
READY_ADR, 16'h0104, Wishbone sub-address of the core-ready register

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cs  in  1  host chip select
rs  in  1  host read strobe, active high
ws  in  1  host write strobe, active high
addrs  in  A+2  host address: [A+1]=status select, [A]=1 encoder/0 decoder, [A-1:0]=channel
w_data  in  8  host write data; low CFG_W bits used
r_data  out  8  host read data
i_wb_adr_e/_d  in  32  Wishbone byte address; [15:0] used
i_wb_dat_e/_d  in  32  Wishbone write data, ignored except at READY_ADR
i_wb_sel_e/_d  in  4  byte select, ignored
i_wb_we_e/_d, i_wb_cyc_e/_d, i_wb_stb_e/_d  in  1  Wishbone controls
o_wb_dat_e/_d  out  32  Wishbone read data
o_wb_ack_e/_d  out  1  Wishbone acknowledge
o_wb_err_e/_d  out  1  tied 0
cfg_done_e/_d  out  1  all N_CH words of the side written since reset
core_ready_e/_d  out  1  side's core has written READY_ADR

Behaviour:
- Reset (synchronous): all channel words 0, configured bitmaps 0, core_ready 0, r_data 0, o_wb_dat 0, o_wb_ack 0, both Wishbone FSMs in IDLE, strobe history 0.
- Host read:
  - Detect rising edge of (cs&rs) from a registered copy.
  - r_data updates on the edge following detection (latency 1 after the sampled edge).
  - Data is zero-extended: channel word when addrs[A+1]=0; {7'b0, core_ready of the side} when addrs[A+1]=1.
- Host write:
  - Commits on the falling edge of (cs&ws): the cycle where registered=1 and current=0.
  - Uses addrs/w_data sampled in that cycle.
  - Sets the channel word to w_data[CFG_W-1:0] and sets that channel's configured bit.
  - Writes with addrs[A+1]=1 are ignored.
- cfg_done = &configured bitmap, registered, one cycle behind the bitmap.
- Wishbone FSM per side, states IDLE, FETCH, ACK:
  - IDLE: stb&cyc&we goes to ACK; stb&cyc&~we goes to FETCH.
  - FETCH: sample the addressed word into o_wb_dat, then go to ACK.
  - ACK: o_wb_ack=1 for exactly one cycle, then IDLE.
  - Read latency: ack 2 cycles after the stb-sample edge. Write latency: 1 cycle.
  - If stb or cyc drops in FETCH, abort to IDLE with no ack.
- Wishbone read address decode, with adr[15:0] sampled in FETCH:
  - DONE_ADR returns {31'b0, cfg_done}.
  - READY_ADR returns {31'b0, core_ready}.
  - Otherwise returns the word of channel adr[A+1:2], zero-extended; adr bits above A+1 are ignored.
- Wishbone write to READY_ADR sets core_ready in the IDLE→ACK transition. It stays set until reset; there is no clear. Writes to any other address are acked and discarded.
- Simultaneous events:
  - A host write commit and a FETCH of the same channel in the same cycle: FETCH returns the old value.
  - Encoder and decoder ports are fully independent.
- Reset asserted mid-transaction: FSM returns to IDLE, no ack is issued, and the pending host strobe edge is lost.

Optional Feature:
CFG_INT_LOCK_EN. When defined:
- A host write to a side whose core_ready=1 is dropped; word and bitmap are unchanged.
- Such a drop sets a sticky lock_err bit, readable at host status address with addrs[A]=side, returned in r_data[1].
- lock_err is cleared by reset only.

When undefined, host writes are never blocked and r_data[1] reads 0.

Decomposition:
- Shared package/include cfg_int_pkg.vh holds DONE_ADR/READY_ADR defaults, Wishbone FSM state encodings (IDLE=2'd0, FETCH=2'd1, ACK=2'd2) and the host address-field positions.
- One sub-module is natural: cfg_wb_slave, the per-side Wishbone FSM plus ready flag. It is instantiated twice and reads the shared register array and cfg_done.

Test Plan:
- Reset then host read enc ch5 (addrs=7'b0_1_00101 for N_CH=32) → r_data=8'h00; o_wb_ack_e/_d=0.
- Host write w_data=8'hFE to dec ch3 → Wishbone read dec adr 0x0C acks on the 2nd cycle after stb, data=32'h6.
- Write all 32 enc channels → cfg_done_e=1 one cycle after the last commit; Wishbone read DONE_ADR on enc=1 and on dec=0.
- Wishbone write READY_ADR on enc → ack 1 cycle later, core_ready_e=1; host status read (addrs=7'b1_1_00000) → r_data=8'h01.
- Drop stb during FETCH → no ack, FSM back in IDLE; next read acks normally.
- With CFG_INT_LOCK_EN: after core_ready_e=1, host write 8'h05 to enc ch0 → word unchanged; status read r_data=8'h03.
